afifo_wptr_ctrl: RTL and testbench

//   Write-side pointer controller for an asynchronous FIFO.
//   - Sequences a binary/Gray write-pointer counter under a valid/ready push handshake.
//   - Drives the write enable and write address of the dual-port RAM.
//   - Synchronises the read domain's Gray pointer into clk and derives full, almost_full and fill level.
//   - Sits in the write clock domain; wptr_gray crosses to the read-side controller.

---
 rtl/afifo_pkg.sv | 27 ++
 rtl/afifo_wptr_ctrl_if.sv | 30 +++
 rtl/gray_sync.sv | 27 ++
 rtl/afifo_wptr_ctrl.sv | 88 ++++++++
 tb/tb_afifo_wptr_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/afifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer controllers:
// pointer-width helper and width-agnostic binary/Gray conversions.
package afifo_pkg;

    // Widest pointer the helpers handle; callers zero-extend in and truncate out.
    localparam int PTR_MAX_W = 32;

    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper bits contribute nothing to the running XOR,
    // so the result is exact for any narrower pointer.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/afifo_wptr_ctrl_if.sv
// Push handshake, RAM write port, pointer crossing and status bundle
// between a producer and the asynchronous FIFO write-pointer controller.
interface afifo_wptr_ctrl_if
    import afifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
);
    localparam int PTR_W = ptr_width(ADDR_WIDTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [PTR_W-1:0]      rptr_gray;
    logic [PTR_W-1:0]      wptr_gray;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  full;
    logic                  almost_full;
    logic [PTR_W-1:0]      level;

    modport master (
        output in_valid, rptr_gray,
        input  in_ready, wptr_gray, wen, waddr, full, almost_full, level
    );

    modport slave (
        input  in_valid, rptr_gray,
        output in_ready, wptr_gray, wen, waddr, full, almost_full, level
    );

endinterface

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into clk.
// Shared by the write- and read-side pointer controllers.
module gray_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    // NOTE: this is a handful of discrete flops, not a RAM, so every stage
    // takes the async reset; otherwise full/level would be X after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/afifo_wptr_ctrl.sv
// Write-side pointer controller of an asynchronous FIFO: push handshake,
// RAM write port, Gray write pointer, and full/almost_full/level from the synced read pointer.
module afifo_wptr_ctrl
    import afifo_pkg::*;
#(
    parameter int ADDR_WIDTH      = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int ALMOST_FULL_THR = 12
) (
    input  logic                    clk,
    input  logic                    resetn,
    afifo_wptr_ctrl_if.slave        bus
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef logic [PTR_W-1:0] ptr_t;

    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    localparam ptr_t FULL_MASK = ptr_t'(3) << (PTR_W - 2);
    localparam ptr_t AF_THR    = ptr_t'(ALMOST_FULL_THR);

    logic init_q;
    ptr_t wbin_q;
    ptr_t wptr_gray_q;
    ptr_t wbin_nxt;
    ptr_t rq;
    ptr_t rbin;
    ptr_t level_w;
    logic full_w;
    logic ready_w;
    logic push;

    gray_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (bus.rptr_gray),
        .q      (rq)
    );

    // NOTE: every signal gets a value on every pass through this block, so
    // no latch is inferred; all terms depend only on flops and in_valid.
    always_comb begin
        wbin_nxt = wbin_q + ptr_t'(1);
        rbin     = ptr_t'(gray2bin(PTR_MAX_W'(rq)));
        full_w   = (wptr_gray_q == (rq ^ FULL_MASK));
        level_w  = wbin_q - rbin;
        ready_w  = init_q & ~full_w;
        push     = bus.in_valid & ready_w;
    end

    // NOTE: state updates use non-blocking assignments so all flops sample
    // their inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            init_q      <= 1'b0;
            wbin_q      <= '0;
            wptr_gray_q <= '0;
        end else begin
            init_q <= 1'b1;
            if (push) begin
                wbin_q      <= wbin_nxt;
                wptr_gray_q <= ptr_t'(bin2gray(PTR_MAX_W'(wbin_nxt)));
            end
        end
    end

    assign bus.in_ready    = ready_w;
    assign bus.wen         = push;
    assign bus.waddr       = wbin_q[ADDR_WIDTH-1:0];
    assign bus.wptr_gray   = wptr_gray_q;
    assign bus.full        = full_w;
    assign bus.level       = level_w;
    assign bus.almost_full = (level_w >= AF_THR);

    // The crossing pointer may change by at most one bit per edge.
    a_gray_step: assert property (@(posedge clk) disable iff (!resetn)
        $countones(wptr_gray_q ^ $past(wptr_gray_q)) <= 1);

    // Only an illegal read pointer (ahead of the write pointer) can trip this.
    a_level_range: assert property (@(posedge clk) disable iff (!resetn)
        level_w <= ptr_t'(DEPTH));

endmodule

// File: tb/tb_afifo_wptr_ctrl.sv
// Self-checking bench for afifo_wptr_ctrl: directed vector table, corner-case
// sequences and randomized push/read traffic against a count-based model.
module tb_afifo_wptr_ctrl;

    localparam int AW    = 4;
    localparam int S     = 2;
    localparam int THR   = 12;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    afifo_wptr_ctrl_if #(.ADDR_WIDTH(AW)) bus();

    afifo_wptr_ctrl #(
        .ADDR_WIDTH      (AW),
        .SYNC_STAGES     (S),
        .ALMOST_FULL_THR (THR)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic       valid;
        int         rd;
        logic       ready;
        logic       wen;
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic       full;
        logic [4:0] level;
        logic       af;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: counts of words written and of reads the write side has seen.
    bit    m_init;
    int    m_wr;
    int    m_rd_hist[$];
    bit    use_model;
    string phase;

    // Outputs captured just before each active edge.
    logic       s_ready, s_wen, s_full, s_af;
    logic [3:0] s_waddr;
    logic [4:0] s_wptr, s_level;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] gray_of(input int n);
        int b;
        b = n % 32;
        return 5'(b ^ (b >> 1));
    endfunction

    function automatic int m_rd_seen();
        return (m_rd_hist.size() == S) ? m_rd_hist[0] : 0;
    endfunction

    task automatic sample();
        s_ready = bus.in_ready;
        s_wen   = bus.wen;
        s_waddr = bus.waddr;
        s_wptr  = bus.wptr_gray;
        s_full  = bus.full;
        s_level = bus.level;
        s_af    = bus.almost_full;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic tick(input logic v, input int rd);
        int   lvl;
        logic e_full, e_ready, e_push;
        bus.in_valid  = v;
        bus.rptr_gray = gray_of(rd);
        #1;
        sample();
        lvl     = m_wr - m_rd_seen();
        e_full  = (lvl == DEPTH);
        e_ready = m_init && !e_full;
        e_push  = v && e_ready;
        if (use_model) begin
            check({phase, ".ready"}, 32'(s_ready), 32'(e_ready));
            check({phase, ".wen"},   32'(s_wen),   32'(e_push));
            check({phase, ".waddr"}, 32'(s_waddr), 32'(m_wr % DEPTH));
            check({phase, ".wptr"},  32'(s_wptr),  32'(gray_of(m_wr)));
            check({phase, ".full"},  32'(s_full),  32'(e_full));
            check({phase, ".level"}, 32'(s_level), 32'(lvl));
            check({phase, ".af"},    32'(s_af),    32'(lvl >= THR));
        end
        @(posedge clk);
        if (e_push) m_wr++;
        m_rd_hist.push_back(rd);
        if (m_rd_hist.size() > S) void'(m_rd_hist.pop_front());
        m_init = 1'b1;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_init = 1'b0;
        m_wr   = 0;
        m_rd_hist.delete();
    endtask

    // Holds reset for two cycles and releases it on a falling edge.
    task automatic do_reset();
        resetn        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.rptr_gray = '0;
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        sample();
        check({tag, ".ready"}, 32'(s_ready), 0);
        check({tag, ".wen"},   32'(s_wen),   0);
        check({tag, ".waddr"}, 32'(s_waddr), 0);
        check({tag, ".wptr"},  32'(s_wptr),  0);
        check({tag, ".full"},  32'(s_full),  0);
        check({tag, ".level"}, 32'(s_level), 0);
        check({tag, ".af"},    32'(s_af),    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd;
        int pre_wr;
        int guard;
        int wlag[$];
        int rd_pct;

        resetn        = 1'b0;
        bus.in_valid  = 1'b1;
        bus.rptr_gray = '0;
        model_reset();
        use_model = 1'b0;
        #2;
        check_all_zero("in_reset");

        // Release with in_valid high, then 16 pushes into an idle reader.
        vecs.push_back('{1'b1, 0, 1'b0, 1'b0, 4'd0,  5'b00000, 1'b0, 5'd0,  1'b0});
        vecs.push_back('{1'b1, 0, 1'b1, 1'b1, 4'd0,  5'b00000, 1'b0, 5'd0,  1'b0});
        vecs.push_back('{1'b1, 0, 1'b1, 1'b1, 4'd1,  5'b00001, 1'b0, 5'd1,  1'b0});
        vecs.push_back('{1'b1, 0, 1'b1, 1'b1, 4'd2,  5'b00011, 1'b0, 5'd2,  1'b0});
        vecs.push_back('{1'b1, 0, 1'b1, 1'b1, 4'd3,  5'b00010, 1'b0, 5'd3,  1'b0});
        vecs.push_back('{1'b1, 0, 1'b1, 1'b1, 4'd4,  5'b00110, 1'b0, 5'd4,  1'b0});
        vecs.push_back('{1'b1, 0, 1'b1, 1'b1, 4'd5,  5'b00111, 1'b0, 5'd5,  1'b0});
        vecs.push_back('{1'b1, 0, 1'b1, 1'b1, 4'd6,  5'b00101, 1'b0, 5'd6,  1'b0});
        vecs.push_back('{1'b1, 0, 1'b1, 1'b1, 4'd7,  5'b00100, 1'b0, 5'd7,  1'b0});
        vecs.push_back('{1'b1, 0, 1'b1, 1'b1, 4'd8,  5'b01100, 1'b0, 5'd8,  1'b0});
        vecs.push_back('{1'b1, 0, 1'b1, 1'b1, 4'd9,  5'b01101, 1'b0, 5'd9,  1'b0});
        vecs.push_back('{1'b1, 0, 1'b1, 1'b1, 4'd10, 5'b01111, 1'b0, 5'd10, 1'b0});
        vecs.push_back('{1'b1, 0, 1'b1, 1'b1, 4'd11, 5'b01110, 1'b0, 5'd11, 1'b0});
        vecs.push_back('{1'b1, 0, 1'b1, 1'b1, 4'd12, 5'b01010, 1'b0, 5'd12, 1'b1});
        vecs.push_back('{1'b1, 0, 1'b1, 1'b1, 4'd13, 5'b01011, 1'b0, 5'd13, 1'b1});
        vecs.push_back('{1'b1, 0, 1'b1, 1'b1, 4'd14, 5'b01001, 1'b0, 5'd14, 1'b1});
        vecs.push_back('{1'b1, 0, 1'b1, 1'b1, 4'd15, 5'b01000, 1'b0, 5'd15, 1'b1});
        vecs.push_back('{1'b1, 0, 1'b0, 1'b0, 4'd0,  5'b11000, 1'b1, 5'd16, 1'b1});
        vecs.push_back('{1'b1, 0, 1'b0, 1'b0, 4'd0,  5'b11000, 1'b1, 5'd16, 1'b1});

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].valid, vecs[i].rd);
            check($sformatf("vec%0d.ready", i), 32'(s_ready), 32'(vecs[i].ready));
            check($sformatf("vec%0d.wen", i),   32'(s_wen),   32'(vecs[i].wen));
            check($sformatf("vec%0d.waddr", i), 32'(s_waddr), 32'(vecs[i].waddr));
            check($sformatf("vec%0d.wptr", i),  32'(s_wptr),  32'(vecs[i].wptr));
            check($sformatf("vec%0d.full", i),  32'(s_full),  32'(vecs[i].full));
            check($sformatf("vec%0d.level", i), 32'(s_level), 32'(vecs[i].level));
            check($sformatf("vec%0d.af", i),    32'(s_af),    32'(vecs[i].af));
        end

        // One read becomes visible only after the synchroniser latency.
        use_model = 1'b1;
        phase = "drain";
        tick(1'b0, 1);
        check("drain.full_edge1", 32'(s_full), 1);
        tick(1'b0, 1);
        check("drain.full_edge2", 32'(s_full), 1);
        tick(1'b0, 1);
        check("drain.full_clear", 32'(s_full),  0);
        check("drain.level",      32'(s_level), 15);
        check("drain.ready",      32'(s_ready), 1);

        // 40 pushes with the reader trailing the writer by three cycles.
        phase = "wrap";
        do_reset();
        rd = 0;
        guard = 0;
        while (m_wr < 40 && guard < 200) begin
            pre_wr = m_wr;
            tick(1'b1, rd);
            wlag.push_back(m_wr);
            if (wlag.size() > 3) rd = wlag.pop_front();
            if (pre_wr == 15) begin
                check("wrap.msb_before16", 32'(s_wptr[4]), 0);
                check("wrap.waddr15",      32'(s_waddr),   15);
            end
            if (pre_wr == 16) begin
                check("wrap.msb_after16", 32'(s_wptr[4]), 1);
                check("wrap.waddr0",      32'(s_waddr),   0);
            end
            if (pre_wr == 32) check("wrap.msb_after32", 32'(s_wptr[4]), 0);
            guard++;
        end
        check("wrap.timeout", 32'(guard < 200), 1);

        // Random pushes and reads, alternating between drain-heavy and fill-heavy windows.
        phase = "rand";
        rd_pct = 80;
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0) rd_pct = (rd_pct == 80) ? 15 : 80;
            if (rd < m_wr && $urandom_range(0, 99) < rd_pct) rd++;
            tick(1'($urandom_range(0, 99) < 70), rd);
        end

        // Reset dropped between edges mid-burst, then the release sequence again.
        phase = "midrst";
        do_reset();
        guard = 0;
        while (m_wr < 7 && guard < 50) begin
            tick(1'b1, 0);
            guard++;
        end
        check("midrst.level7", 32'(m_wr == 7), 1);
        bus.in_valid = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("midrst.async");
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        tick(1'b1, 0);
        check("rerel.ready_edge1", 32'(s_ready), 0);
        check("rerel.wptr",        32'(s_wptr),  0);
        check("rerel.level",       32'(s_level), 0);
        check("rerel.full",        32'(s_full),  0);
        tick(1'b1, 0);
        check("rerel.ready_edge2", 32'(s_ready), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
